// File: rtl/tv80_env_pkg.sv
// ---------------------------------------------------------------------------
// tv80_env_pkg
// Shared definitions for the TV80 test-environment memory controller:
//   - state_t      : controller state encoding (IDLE, WAIT, ACCESS, HOLD)
//   - ERR_CNT_MAX  : saturation value of the blocked-write counter
// ---------------------------------------------------------------------------
package tv80_env_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/tv80_memctl_wait_cnt.sv
// ---------------------------------------------------------------------------
// tv80_wait_cnt
// Loadable down-counter with a zero flag. Used to time wait states.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_load          load i_load_val (has priority over i_dec)
//   i_load_val      value to load
//   i_dec           decrement by one; holds at zero
//   o_zero          count is zero
// ---------------------------------------------------------------------------
module tv80_wait_cnt
    import tv80_env_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tv80_memctl.sv
// ---------------------------------------------------------------------------
// tv80_memctl
// Region-decoding memory controller for the TV80 test environment. Splits
// the address space into NREG regions (top log2(NREG) address bits), adds a
// per-region number of wait states, and produces level read selects and
// one-cycle write strobes. Writes to read-only regions are blocked, flagged
// (sticky ro_err) and counted (saturating err_cnt).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   mreq_n rd_n wr_n rfsh_n iorq_n   CPU bus strobes
//   A          [ADDR_W]          CPU address
//   wait_cfg   [NREG*WAIT_W]     wait states, region r at [r*WAIT_W +: WAIT_W]
//   ro_mask    [NREG]            read-only region mask
//   err_clr                      synchronous clear of ro_err / err_cnt
//   rd_cs      [NREG]            one-hot read select (held while rd_n low)
//   wr_cs      [NREG]            one-hot write strobe, one cycle wide
//   wait_n                       wait request to the CPU, active low
//   ro_err                       sticky blocked-write flag
//   err_cnt    [8]               blocked-write count, saturating
//
// Build option: TV80_MEMCTL_IO_WAIT_EN -- I/O read/write cycles get one wait
// state (no select). Without it iorq_n is ignored.
// ---------------------------------------------------------------------------
module tv80_memctl
    import tv80_env_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    parameter int WAIT_W = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     mreq_n,
    input  logic                     rd_n,
    input  logic                     wr_n,
    input  logic                     rfsh_n,
    input  logic                     iorq_n,
    input  logic [ADDR_W-1:0]        A,
    input  logic [NREG*WAIT_W-1:0]   wait_cfg,
    input  logic [NREG-1:0]          ro_mask,
    input  logic                     err_clr,
    output logic [NREG-1:0]          rd_cs,
    output logic [NREG-1:0]          wr_cs,
    output logic                     wait_n,
    output logic                     ro_err,
    output logic [7:0]               err_cnt
);

    localparam int RB = $clog2(NREG);

    if (NREG < 2 || NREG > 16 || (NREG & (NREG - 1)) != 0 || DATA_W < 1) begin : g_bad_cfg
        $error("tv80_memctl: NREG must be a power of two in 2..16");
    end

    // ---------------- decode of the current bus cycle ----------------
    logic [RB-1:0]     w_reg;
    logic [WAIT_W-1:0] w_wcfg;
    logic              w_ro;
    logic [NREG-1:0]   w_sel_now;
    logic              w_mem_req;
    logic              w_io_req;
    logic              w_unused;

    assign w_reg     = A[ADDR_W-1 -: RB];
    assign w_wcfg    = wait_cfg[int'(w_reg)*WAIT_W +: WAIT_W];
    assign w_ro      = ro_mask[w_reg];
    assign w_sel_now = NREG'(1) << w_reg;
    // Refresh cycles are excluded here, so they can never start a cycle.
    assign w_mem_req = !mreq_n && rfsh_n && (!rd_n || !wr_n);

`ifdef TV80_MEMCTL_IO_WAIT_EN
    // Interrupt acknowledge has rd_n = wr_n = 1 and is ignored by this term.
    assign w_io_req  = !iorq_n && mreq_n && (!rd_n || !wr_n);
`else
    assign w_io_req  = 1'b0;
`endif

    assign w_unused = ^{A[ADDR_W-RB-1:0], iorq_n};

    // ---------------- latched cycle attributes ----------------
    state_t          r_state;
    logic [RB-1:0]   r_reg;
    logic            r_rd;
    logic            r_ro;
    logic            r_io;
    logic [NREG-1:0] r_rd_cs;
    logic [NREG-1:0] r_wr_cs;
    logic            r_wait_n;
    logic            r_ro_err;
    logic [7:0]      r_err_cnt;

    logic [NREG-1:0] w_sel_lat;
    logic            w_abort;
    logic            w_release;

    assign w_sel_lat = NREG'(1) << r_reg;
    // A waiting cycle is abandoned if its strobes go away.
    assign w_abort   = (r_io ? iorq_n : mreq_n) || (rd_n && wr_n);
    assign w_release = r_io ? iorq_n : mreq_n;

    // ---------------- wait-state counter ----------------
    // The counter holds the number of wait cycles still to come after the
    // current one, so it is loaded with W-1 and the exit to ACCESS happens
    // on the edge where it already reads zero: wait_n is then low W clocks.
    logic              w_cnt_load;
    logic [WAIT_W-1:0] w_cnt_val;
    logic              w_cnt_dec;
    logic              w_cnt_zero;

    assign w_cnt_load = (r_state == ST_IDLE) &&
                        (w_io_req || (w_mem_req && w_wcfg != '0));
    assign w_cnt_val  = w_io_req ? '0 : w_wcfg - WAIT_W'(1);
    assign w_cnt_dec  = (r_state == ST_WAIT);

    tv80_wait_cnt #(.W(WAIT_W)) u_wait_cnt (
        .i_clk      (clk),
        .i_rst_n    (reset_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // ---------------- entry into ACCESS ----------------
    // ACCESS is entered either straight from IDLE (W=0, using the live
    // decode) or from WAIT (using the latched attributes).
    logic            w_go_acc;
    logic            w_acc_rd;
    logic            w_acc_ro;
    logic            w_acc_io;
    logic [NREG-1:0] w_acc_sel;
    logic            w_block;

    always_comb begin
        w_go_acc  = 1'b0;
        w_acc_rd  = r_rd;
        w_acc_ro  = r_ro;
        w_acc_io  = r_io;
        w_acc_sel = w_sel_lat;
        if (r_state == ST_IDLE && w_mem_req && w_wcfg == '0) begin
            w_go_acc  = 1'b1;
            w_acc_rd  = !rd_n;
            w_acc_ro  = w_ro;
            w_acc_io  = 1'b0;
            w_acc_sel = w_sel_now;
        end else if (r_state == ST_WAIT && !w_abort && w_cnt_zero) begin
            w_go_acc  = 1'b1;
        end
    end

    assign w_block = w_go_acc && !w_acc_rd && w_acc_ro && !w_acc_io;

    // ---------------- controller FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_reg    <= '0;
            r_rd     <= 1'b0;
            r_ro     <= 1'b0;
            r_io     <= 1'b0;
            r_rd_cs  <= '0;
            r_wr_cs  <= '0;
            r_wait_n <= 1'b1;
        end else begin
            r_wr_cs <= '0;
            // Region, direction and read-only bit are frozen at sampling, so
            // later wait_cfg / ro_mask changes do not touch this cycle.
            if (r_state == ST_IDLE && (w_mem_req || w_io_req)) begin
                r_reg <= w_reg;
                r_rd  <= !rd_n;
                r_ro  <= w_ro;
                r_io  <= w_io_req;
            end
            if (w_go_acc) begin
                r_state  <= ST_ACCESS;
                r_wait_n <= 1'b1;
                r_rd_cs  <= (w_acc_rd && !w_acc_io) ? w_acc_sel : '0;
                r_wr_cs  <= (!w_acc_rd && !w_acc_ro && !w_acc_io) ? w_acc_sel : '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_rd_cs <= '0;
                        if (w_cnt_load) begin
                            r_wait_n <= 1'b0;
                            r_state  <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (w_abort) begin
                            r_wait_n <= 1'b1;
                            r_state  <= ST_IDLE;
                        end
                    end
                    ST_ACCESS: begin
                        r_rd_cs <= (r_rd && !r_io && !rd_n) ? w_sel_lat : '0;
                        r_state <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (w_release) begin
                            r_rd_cs <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_rd_cs <= (r_rd && !r_io && !rd_n) ? w_sel_lat : '0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // ---------------- blocked-write bookkeeping ----------------
    // err_clr has priority over a blocked write on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ro_err  <= 1'b0;
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_ro_err  <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_block) begin
            r_ro_err <= 1'b1;
            if (r_err_cnt != ERR_CNT_MAX) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign rd_cs   = r_rd_cs;
    assign wr_cs   = r_wr_cs;
    assign wait_n  = r_wait_n;
    assign ro_err  = r_ro_err;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_tv80_memctl.sv
// ---------------------------------------------------------------------------
// tb_tv80_memctl
// Self-checking bench for tv80_memctl (NREG=4, WAIT_W=3, ADDR_W=16).
// Bus cycles are driven as whole transactions and their observed shape
// (wait-low count, select timing, strobes seen) is compared with values
// computed from the region / wait / read-only rules.
// ---------------------------------------------------------------------------
module tb_tv80_memctl;

    logic        clk = 1'b0;
    logic        reset_n, mreq_n, rd_n, wr_n, rfsh_n, iorq_n, err_clr;
    logic [15:0] A;
    logic [11:0] wait_cfg;
    logic [3:0]  ro_mask;
    logic [3:0]  rd_cs, wr_cs;
    logic        wait_n, ro_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int m_err  = 0;   // model: blocked writes since last clear/reset

    always #5 clk = ~clk;

    tv80_memctl #(.ADDR_W(16), .DATA_W(8), .NREG(4), .WAIT_W(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mreq_n   (mreq_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .rfsh_n   (rfsh_n),
        .iorq_n   (iorq_n),
        .A        (A),
        .wait_cfg (wait_cfg),
        .ro_mask  (ro_mask),
        .err_clr  (err_clr),
        .rd_cs    (rd_cs),
        .wr_cs    (wr_cs),
        .wait_n   (wait_n),
        .ro_err   (ro_err),
        .err_cnt  (err_cnt)
    );

    // ---------------- reference rules ----------------
    function automatic int region_of(input logic [15:0] addr);
        return int'(addr) / 16384;
    endfunction

    function automatic int waits_of(input logic [11:0] cfg, input int r);
        return (int'(cfg) >> (3 * r)) % 8;
    endfunction

    function automatic int sat_cnt(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    // ---------------- transaction driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1; iorq_n = 1'b1;
    endtask

    // One CPU memory cycle: strobes held until the access plus `hold` more
    // clocks, optionally scrambling wait_cfg/ro_mask after sampling.
    task automatic bus_cycle(input logic [15:0] addr, input bit is_rd,
                             input int hold, input bit scramble,
                             output int nwait, output int first_sel,
                             output logic [3:0] rd_seen, output logic [3:0] wr_seen,
                             output int wr_pulses, output int rd_cycles,
                             output bit end_ok);
        A = addr; mreq_n = 1'b0; rfsh_n = 1'b1; iorq_n = 1'b1;
        rd_n = !is_rd; wr_n = is_rd;
        nwait = 0; first_sel = -1; rd_seen = '0; wr_seen = '0;
        wr_pulses = 0; rd_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (scramble && i == 0) begin
                wait_cfg = 12'($urandom);
                ro_mask  = 4'($urandom);
            end
            if (!wait_n) nwait++;
            if ((rd_cs | wr_cs) != 4'd0 && first_sel < 0) first_sel = i;
            rd_seen |= rd_cs;
            wr_seen |= wr_cs;
            if (wr_cs != 4'd0) wr_pulses++;
            if (rd_cs != 4'd0) rd_cycles++;
            if (wait_n && i >= nwait + hold) break;
        end
        bus_idle();
        step();
        end_ok = (rd_cs == 4'd0) && (wr_cs == 4'd0) && wait_n;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; err_clr = 1'b0; A = '0; wait_cfg = '0; ro_mask = '0;
        bus_idle();
        #12;
        checks++; if (rd_cs !== 4'd0) begin errors++; $display("FAIL reset_rd_cs got %b want 0000", rd_cs); end
        checks++; if (wr_cs !== 4'd0) begin errors++; $display("FAIL reset_wr_cs got %b want 0000", wr_cs); end
        checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL reset_wait_n got %b want 1", wait_n); end
        checks++; if (ro_err !== 1'b0) begin errors++; $display("FAIL reset_ro_err got %b want 0", ro_err); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        @(negedge clk); reset_n = 1'b1;
        step();
        m_err = 0;
    endtask

    task automatic test_read_nowait();
        int nw, fs, wp, rc; logic [3:0] rs, ws; bit ok;
        wait_cfg = '0; ro_mask = '0;
        bus_cycle(16'h0100, 1'b1, 1, 1'b0, nw, fs, rs, ws, wp, rc, ok);
        checks++; if (nw != 0) begin errors++; $display("FAIL rd0_wait got %0d want 0", nw); end
        checks++; if (fs != 0) begin errors++; $display("FAIL rd0_sel_time got %0d want 0", fs); end
        checks++; if (rs !== 4'b0001) begin errors++; $display("FAIL rd0_rd_cs got %b want 0001", rs); end
        checks++; if (ws !== 4'b0000) begin errors++; $display("FAIL rd0_wr_cs got %b want 0000", ws); end
        checks++; if (rc != 2) begin errors++; $display("FAIL rd0_hold got %0d want 2", rc); end
        checks++; if (!ok) begin errors++; $display("FAIL rd0_end got 0 want 1"); end
    endtask

    task automatic test_write_wait();
        int nw, fs, wp, rc; logic [3:0] rs, ws; bit ok;
        wait_cfg = 12'd3 << 6; ro_mask = '0;
        bus_cycle(16'h8000, 1'b0, 0, 1'b0, nw, fs, rs, ws, wp, rc, ok);
        checks++; if (nw != 3) begin errors++; $display("FAIL wr3_wait got %0d want 3", nw); end
        checks++; if (fs != 3) begin errors++; $display("FAIL wr3_sel_time got %0d want 3", fs); end
        checks++; if (ws !== 4'b0100) begin errors++; $display("FAIL wr3_wr_cs got %b want 0100", ws); end
        checks++; if (wp != 1) begin errors++; $display("FAIL wr3_pulses got %0d want 1", wp); end
        checks++; if (rs !== 4'b0000) begin errors++; $display("FAIL wr3_rd_cs got %b want 0000", rs); end
        checks++; if (!ok) begin errors++; $display("FAIL wr3_end got 0 want 1"); end
    endtask

    task automatic test_ro_write();
        int nw, fs, wp, rc; logic [3:0] rs, ws; bit ok;
        wait_cfg = '0; ro_mask = 4'b0001;
        bus_cycle(16'h0010, 1'b0, 0, 1'b0, nw, fs, rs, ws, wp, rc, ok);
        m_err++;
        checks++; if (ws !== 4'b0000) begin errors++; $display("FAIL ro_wr_cs got %b want 0000", ws); end
        checks++; if (ro_err !== 1'b1) begin errors++; $display("FAIL ro_flag got %b want 1", ro_err); end
        checks++; if (int'(err_cnt) != sat_cnt(m_err)) begin errors++; $display("FAIL ro_cnt1 got %0d want %0d", err_cnt, sat_cnt(m_err)); end
        for (int k = 0; k < 299; k++) begin
            bus_cycle(16'h0010, 1'b0, 0, 1'b0, nw, fs, rs, ws, wp, rc, ok);
            m_err++;
        end
        checks++; if (int'(err_cnt) != sat_cnt(m_err)) begin errors++; $display("FAIL ro_sat got %0d want %0d", err_cnt, sat_cnt(m_err)); end
        err_clr = 1'b1; step(); err_clr = 1'b0; m_err = 0;
        checks++; if (err_cnt !== 8'd0 || ro_err !== 1'b0) begin errors++; $display("FAIL ro_clr got cnt=%0d flag=%b want 0 0", err_cnt, ro_err); end
        // clear and blocked write on the same edge: the clear wins
        err_clr = 1'b1;
        bus_cycle(16'h0010, 1'b0, 0, 1'b0, nw, fs, rs, ws, wp, rc, ok);
        err_clr = 1'b0;
        checks++; if (err_cnt !== 8'd0 || ro_err !== 1'b0) begin errors++; $display("FAIL ro_clr_wins got cnt=%0d flag=%b want 0 0", err_cnt, ro_err); end
        ro_mask = '0;
    endtask

    task automatic test_refresh();
        int nw = 0; logic [3:0] seen = '0;
        wait_cfg = 12'hFFF;
        A = 16'hC000; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (!wait_n) nw++;
            seen |= rd_cs | wr_cs;
        end
        bus_idle(); step(); step();
        checks++; if (seen !== 4'd0) begin errors++; $display("FAIL rfsh_sel got %b want 0000", seen); end
        checks++; if (nw != 0) begin errors++; $display("FAIL rfsh_wait got %0d want 0", nw); end
    endtask

    task automatic test_abort();
        int nw, fs, wp, rc; logic [3:0] rs, ws; bit ok;
        wait_cfg = 12'd5 << 3;
        A = 16'h4000; mreq_n = 1'b0; rfsh_n = 1'b1; rd_n = 1'b0; wr_n = 1'b1;
        step(); step();
        checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL abort_waiting got %b want 0", wait_n); end
        bus_idle(); step();
        checks++; if (wait_n !== 1'b1 || rd_cs !== 4'd0) begin errors++; $display("FAIL abort_release got wait_n=%b rd_cs=%b want 1 0000", wait_n, rd_cs); end
        step();
        bus_cycle(16'h4000, 1'b1, 0, 1'b0, nw, fs, rs, ws, wp, rc, ok);
        checks++; if (nw != 5 || fs != 5 || rs !== 4'b0010) begin errors++; $display("FAIL abort_next got wait=%0d sel_t=%0d rd_cs=%b want 5 5 0010", nw, fs, rs); end
    endtask

    task automatic test_reset_mid();
        int nw, fs, wp, rc; logic [3:0] rs, ws; bit ok;
        wait_cfg = 12'd5 << 9;
        A = 16'hC000; mreq_n = 1'b0; rfsh_n = 1'b1; rd_n = 1'b0; wr_n = 1'b1;
        step(); step();
        #2 reset_n = 1'b0;
        #1;
        m_err = 0;
        checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL rstmid_wait_n got %b want 1", wait_n); end
        checks++; if (rd_cs !== 4'd0 || wr_cs !== 4'd0) begin errors++; $display("FAIL rstmid_sel got %b/%b want 0000/0000", rd_cs, wr_cs); end
        bus_idle();
        #13 reset_n = 1'b1;
        step();
        bus_cycle(16'hC000, 1'b1, 0, 1'b0, nw, fs, rs, ws, wp, rc, ok);
        checks++; if (nw != 5 || fs != 5 || rs !== 4'b1000 || !ok) begin errors++; $display("FAIL rstmid_next got wait=%0d sel_t=%0d rd_cs=%b end=%0d want 5 5 1000 1", nw, fs, rs, ok); end
    endtask

    task automatic test_io();
        int nw = 0; logic [3:0] seen = '0; int want;
`ifdef TV80_MEMCTL_IO_WAIT_EN
        want = 1;
`else
        want = 0;
`endif
        A = 16'h0042; mreq_n = 1'b1; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (!wait_n) nw++;
            seen |= rd_cs | wr_cs;
        end
        bus_idle(); step(); step();
        checks++; if (nw != want) begin errors++; $display("FAIL io_wait got %0d want %0d", nw, want); end
        checks++; if (seen !== 4'd0) begin errors++; $display("FAIL io_sel got %b want 0000", seen); end
    endtask

    task automatic test_random();
        int nw, fs, wp, rc; logic [3:0] rs, ws; bit ok;
        int r, w, hold, e_fs; bit is_rd, ro, blocked;
        logic [15:0] addr; logic [3:0] onehot;
        for (int t = 0; t < 40; t++) begin
            wait_cfg = 12'($urandom);
            ro_mask  = 4'($urandom);
            addr     = 16'($urandom);
            is_rd    = 1'($urandom);
            hold     = $urandom_range(0, 2);
            r        = region_of(addr);
            w        = waits_of(wait_cfg, r);
            ro       = ro_mask[r];
            onehot   = 4'(1 << r);
            blocked  = !is_rd && ro;
            e_fs     = blocked ? -1 : w;
            bus_cycle(addr, is_rd, hold, 1'(t % 2), nw, fs, rs, ws, wp, rc, ok);
            if (blocked) m_err++;
            checks++; if (nw != w) begin errors++; $display("FAIL rnd%0d_wait got %0d want %0d", t, nw, w); end
            checks++; if (fs != e_fs) begin errors++; $display("FAIL rnd%0d_sel_time got %0d want %0d", t, fs, e_fs); end
            checks++; if (rs !== (is_rd ? onehot : 4'd0)) begin errors++; $display("FAIL rnd%0d_rd_cs got %b want %b", t, rs, is_rd ? onehot : 4'd0); end
            checks++; if (ws !== ((!is_rd && !ro) ? onehot : 4'd0)) begin errors++; $display("FAIL rnd%0d_wr_cs got %b want %b", t, ws, (!is_rd && !ro) ? onehot : 4'd0); end
            checks++; if (wp != ((!is_rd && !ro) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_wr_pulses got %0d", t, wp); end
            checks++; if (rc != (is_rd ? hold + 1 : 0)) begin errors++; $display("FAIL rnd%0d_rd_len got %0d want %0d", t, rc, is_rd ? hold + 1 : 0); end
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_end got 0 want 1", t); end
            checks++; if (int'(err_cnt) != sat_cnt(m_err) || ro_err !== (m_err > 0)) begin errors++; $display("FAIL rnd%0d_err got cnt=%0d flag=%b want %0d %0d", t, err_cnt, ro_err, sat_cnt(m_err), m_err > 0); end
        end
    endtask

    initial begin
        test_reset();
        test_read_nowait();
        test_write_wait();
        test_ro_write();
        test_refresh();
        test_abort();
        test_reset_mid();
        test_io();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tv80_memctl.md
# tv80_memctl

Parametrised memory controller for the TV80 test environment. Decodes CPU memory cycles into NREG address regions, inserts a per-region programmable number of wait states on `wait_n`, and generates one-shot write strobes and level read strobes per region. Writes to read-only regions are blocked and counted. It sits between the `tv80s` bus pins and the environment's memory models, and replaces hand-coded chip-select equations and ad-hoc wait-state generation.

## Interface
- `ADDR_W`, 16, CPU address width.
- `DATA_W`, 8, data width.
- `NREG`, 4, number of regions; power of two, 2..16; region index = top log2(NREG) address bits.
- `WAIT_W`, 3, width of each region's wait-state count.

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mreq_n`, `rd_n`, `wr_n`, `rfsh_n`, `iorq_n`  in  1 each  CPU bus strobes.
- `A`  in  ADDR_W  CPU address.
- `wait_cfg`  in  NREG*WAIT_W  wait states per region; region r occupies bits [r*WAIT_W +: WAIT_W].
- `ro_mask`  in  NREG  bit r set means region r is read-only.
- `rd_cs`  out  NREG  one-hot read select.
- `wr_cs`  out  NREG  one-hot write strobe, one cycle wide.
- `wait_n`  out  1  wait request to CPU, active low.
- `ro_err`  out  1  sticky flag: a write to a read-only region occurred.
- `err_cnt`  out  8  count of blocked writes, saturating.
- `err_clr`  in  1  synchronous clear of `ro_err` and `err_cnt`.

## Operation
- States: IDLE, WAIT, ACCESS, HOLD.
- IDLE: at a posedge sampling `mreq_n`=0, `rfsh_n`=1, and (`rd_n`=0 or `wr_n`=0), latch the region index, that region's wait count W, its read-only bit and the direction. W=0 goes to ACCESS; W>0 loads the counter with W, drives `wait_n`=0 and goes to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, set `wait_n`=1 and go to ACCESS.
- ACCESS (one cycle):
  - Read: `rd_cs[r]`=1.
  - Write to a writable region: `wr_cs[r]`=1 for this cycle only.
  - Write to a read-only region: `wr_cs` stays 0, `ro_err` is set, and `err_cnt` increments, saturating at 255.
  - Next state is HOLD.
- HOLD: a read keeps `rd_cs[r]` asserted while `rd_n`=0. The block returns to IDLE on the first posedge with `mreq_n`=1.
- Refresh cycles (`mreq_n`=0 with `rfsh_n`=0) never produce a select or a wait.
- Strobes deasserted during WAIT (aborted cycle): go to IDLE, set `wait_n`=1, no select.
- `wait_cfg` and `ro_mask` changes during a cycle have no effect until the next cycle.
- `err_clr` together with a blocked write in the same cycle: the clear wins. Result is `err_cnt`=0, `ro_err`=0.

## Timing
- Reset values: state IDLE, `wait_n`=1, `rd_cs`=0, `wr_cs`=0, `ro_err`=0, `err_cnt`=0, counter 0.
- Reset assertion mid-cycle forces all reset values immediately, without waiting for a clock edge.
- All outputs are registered.
- `wait_n` falls 1 clock after the request is sampled and stays low for exactly W clocks.
- First select comes W+1 clocks after the request is sampled.
- `wr_cs` is asserted exactly once per write cycle.
- Back-to-back cycles: a new request is only recognised after the block has seen `mreq_n`=1 in HOLD.

## Configuration
- `TV80_MEMCTL_IO_WAIT_EN` defined:
  - `iorq_n`=0 with (`rd_n`=0 or `wr_n`=0), sampled in IDLE, takes the WAIT path with a fixed count of 1 wait state, and no select is asserted.
  - Interrupt acknowledge cycles (`iorq_n`=0 with `m1_n` low implied by `rd_n`=`wr_n`=1) are ignored.
- Not defined: `iorq_n` is ignored entirely.

## Structure
- Shared package `tv80_env_pkg`: state encoding constants (IDLE, WAIT, ACCESS, HOLD) and the `err_cnt` saturation value.
- One sub-module, `tv80_wait_cnt`: a loadable down-counter with a zero flag, instantiated once.
- Region decode and select generation are inline.

## Test plan
- NREG=4, `wait_cfg` all 0, read at A=16'h0100 → `rd_cs`=4'b0001 one clock after sampling, `wait_n` never low.
- `wait_cfg` region 2 = 3, write at A=16'h8000 → `wait_n` low for 3 clocks, then `wr_cs`=4'b0100 for exactly 1 clock.
- `ro_mask`=4'b0001, write at 16'h0010 → `wr_cs` stays 0, `ro_err`=1, `err_cnt`=1. After 300 such writes `err_cnt`=255. `err_clr` returns both to 0.
- Refresh cycle (`mreq_n`=0, `rfsh_n`=0) at 16'hC000 → no select, `wait_n`=1.
- Assert `reset_n`=0 during WAIT with W=5 → `wait_n`=1 and all selects 0 immediately. After release, the next read completes normally.
- With `TV80_MEMCTL_IO_WAIT_EN` defined, I/O read → `wait_n` low for 1 clock, `rd_cs`=0. Without the macro → `wait_n` stays 1.
